// File: rtl/ad7693_pkg.sv
// ---------------------------------------------------------------------------
// ad7693_pkg : shared constants, FSM encoding and error-flag indices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ad7693_pkg;

  localparam int C_DATA_WIDTH  = 16;
  localparam int C_CONV_CYCLES = 160;

  localparam int ERR_CNV_EARLY  = 0;
  localparam int ERR_CNV_RETRIG = 1;
  localparam int ERR_SCK_EXTRA  = 2;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_CONVERT = 5'b00010,
    ST_HOLD    = 5'b00100,
    ST_SHIFT   = 5'b01000,
    ST_DONE    = 5'b10000
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ad7693_sync_edge.sv
// ---------------------------------------------------------------------------
// ad7693_sync_edge : multi-stage synchronizer with rise/fall pulse outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ad7693_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

`default_nettype wire

// File: rtl/ad7693_emulator.sv
// ---------------------------------------------------------------------------
// ad7693_emulator : oversampled AD7693 responder, 3-wire mode without busy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ad7693_emulator
  import ad7693_pkg::*;
#(
  parameter int DATA_WIDTH   = C_DATA_WIDTH,
  parameter int CONV_CYCLES  = C_CONV_CYCLES,
  parameter int SYNC_STAGES  = 2,
  parameter int PATTERN_MODE = 0
) (
  input  logic                  fpga_clk,
  input  logic                  reset,
  input  logic                  adc_cnv,
  input  logic                  adc_sck,
  output logic                  adc_sdo,
  output logic                  adc_sdo_oe,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  busy,
  output logic [15:0]           conv_count,
  output logic [2:0]            err_flags,
  input  logic                  err_clear
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic cnv_level, cnv_rise, cnv_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sck_unused;

  ad7693_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cnv (
    .clk_i  (fpga_clk),
    .rst_i  (reset),
    .async_i(adc_cnv),
    .level_o(cnv_level),
    .rise_o (cnv_rise),
    .fall_o (cnv_fall)
  );

  ad7693_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i  (fpga_clk),
    .rst_i  (reset),
    .async_i(adc_sck),
    .level_o(sck_level),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  assign sck_unused = sck_level ^ sck_rise;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shreg_q, word_q, shadow_q, ramp_q;
  logic                  ready_q, busy_q, sdo_q, oe_q;
  logic [15:0]           conv_count_q;
  logic [2:0]            err_q;

  logic                  start;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word_d;

  // A CNV rise restarts from IDLE, SHIFT or DONE; short reads are legal.
  assign start  = cnv_rise && (state_q == ST_IDLE || state_q == ST_SHIFT || state_q == ST_DONE);
  assign accept = sample_valid && ready_q && (PATTERN_MODE == 0);

  always_comb begin
    word_d = word_q;
    if (PATTERN_MODE != 0) begin
      word_d = ramp_q;
    end else if (!ready_q) begin
      word_d = shadow_q;
    end
  end

  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      word_q       <= '0;
      shadow_q     <= '0;
      ramp_q       <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      sdo_q        <= 1'b0;
      oe_q         <= 1'b0;
      conv_count_q <= '0;
      err_q        <= '0;
    end else begin
      if (accept) begin
        shadow_q <= sample_in;
        ready_q  <= 1'b0;
      end
      // Error events are assigned later in this block, so they win over a clear.
      if (err_clear) begin
        err_q <= '0;
      end

      if (start) begin
        word_q       <= word_d;
        shreg_q      <= word_d;
        if (PATTERN_MODE != 0) begin
          ramp_q <= ramp_q + 1'b1;
        end else if (!ready_q) begin
          ready_q <= 1'b1;
        end
        cnt_q        <= '0;
        conv_count_q <= conv_count_q + 1'b1;
        busy_q       <= 1'b1;
        oe_q         <= 1'b0;
        sdo_q        <= 1'b0;
        state_q      <= ST_CONVERT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            oe_q <= 1'b0;
          end
          ST_CONVERT: begin
            if (cnv_rise) err_q[ERR_CNV_RETRIG] <= 1'b1;
            if (cnv_fall) err_q[ERR_CNV_EARLY]  <= 1'b1;
            if (cnt_q == CW'(CONV_CYCLES - 1)) begin
              busy_q <= 1'b0;
              if (cnv_level) begin
                state_q <= ST_HOLD;
              end else begin
                state_q <= ST_SHIFT;
                oe_q    <= 1'b1;
                sdo_q   <= shreg_q[DATA_WIDTH-1];
                bit_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnv_fall) begin
              state_q <= ST_SHIFT;
              oe_q    <= 1'b1;
              sdo_q   <= shreg_q[DATA_WIDTH-1];
              bit_q   <= '0;
            end
          end
          ST_SHIFT: begin
            if (sck_fall) begin
              shreg_q <= shreg_q << 1;
              bit_q   <= bit_q + 1'b1;
              if (bit_q == BW'(DATA_WIDTH - 1)) begin
                sdo_q   <= 1'b0;
                state_q <= ST_DONE;
              end else begin
                sdo_q <= shreg_q[DATA_WIDTH-2];
              end
            end
          end
          ST_DONE: begin
            sdo_q <= 1'b0;
            if (sck_fall) err_q[ERR_SCK_EXTRA] <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc_sdo      = sdo_q;
  assign adc_sdo_oe   = oe_q;
  assign busy         = busy_q;
  assign sample_ready = ready_q && (PATTERN_MODE == 0);
  assign conv_count   = conv_count_q;
  assign err_flags    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ad7693_emulator.sv
// ---------------------------------------------------------------------------
// tb_ad7693_emulator : randomized self-checking bench for ad7693_emulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ad7693_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cnv = 1'b0, sck = 1'b1, cnv_r = 1'b0, sck_r = 1'b1;
  logic        err_clear = 1'b0, valid = 1'b0;
  logic [15:0] sample_in = '0;

  logic        sdo, oe, ready, busy;
  logic [15:0] cc;
  logic [2:0]  err;
  logic        sdo_r, oe_r, ready_r, busy_r;
  logic [15:0] cc_r;
  logic [2:0]  err_r;

  ad7693_emulator #(.DATA_WIDTH(16), .CONV_CYCLES(160), .SYNC_STAGES(2), .PATTERN_MODE(0)) dut (
    .fpga_clk(clk), .reset(reset), .adc_cnv(cnv), .adc_sck(sck),
    .adc_sdo(sdo), .adc_sdo_oe(oe), .sample_in(sample_in), .sample_valid(valid),
    .sample_ready(ready), .busy(busy), .conv_count(cc), .err_flags(err),
    .err_clear(err_clear)
  );

  // Small ramp instance so that the 4-bit wrap is reachable in a few frames.
  ad7693_emulator #(.DATA_WIDTH(4), .CONV_CYCLES(8), .SYNC_STAGES(2), .PATTERN_MODE(1)) dut_r (
    .fpga_clk(clk), .reset(reset), .adc_cnv(cnv_r), .adc_sck(sck_r),
    .adc_sdo(sdo_r), .adc_sdo_oe(oe_r), .sample_in(sample_in[3:0]), .sample_valid(valid),
    .sample_ready(ready_r), .busy(busy_r), .conv_count(cc_r), .err_flags(err_r),
    .err_clear(err_clear)
  );

  int          checks = 0;
  int          fails  = 0;

  // Reference model of the sample path and counters
  logic [15:0] m_shadow = '0, m_last = '0, m_cc = '0;
  bit          m_full = 1'b0;
  logic [2:0]  m_err = '0;
  int          m_ramp_n = 0;

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cnv(input bit r, input logic v);
    if (r) cnv_r = v; else cnv = v;
  endtask

  task automatic set_sck(input bit r, input logic v);
    if (r) sck_r = v; else sck = v;
  endtask

  function automatic logic get_sdo(input bit r);
    return r ? sdo_r : sdo;
  endfunction

  task automatic handshake(input logic [15:0] v);
    sample_in = v;
    valid     = 1'b1;
    clocks(1);
    valid     = 1'b0;
    if (!m_full) begin
      m_shadow = v;
      m_full   = 1'b1;
    end
  endtask

  task automatic model_start(output logic [15:0] w);
    if (m_full) begin
      m_last = m_shadow;
      m_full = 1'b0;
    end
    w    = m_last;
    m_cc = m_cc + 16'd1;
  endtask

  task automatic conv_phase(input bit r, input int hi);
    int conv;
    conv = r ? 8 : 160;
    set_cnv(r, 1'b1);
    clocks(hi);
    set_cnv(r, 1'b0);
    clocks(((hi < conv + 10) ? (conv + 10 - hi) : 0) + 10);
  endtask

  task automatic read_bits(input bit r, input int nfalls, input int width,
                           output logic [15:0] w, output logic last);
    w = '0;
    w = {w[14:0], get_sdo(r)};
    for (int k = 1; k <= nfalls; k++) begin
      set_sck(r, 1'b0);
      clocks(5);
      set_sck(r, 1'b1);
      clocks(5);
      if (k < width) w = {w[14:0], get_sdo(r)};
    end
    last = get_sdo(r);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    clocks(1);
    err_clear = 1'b0;
    clocks(1);
    m_err = '0;
  endtask

  task automatic test_reset();
    clocks(3);
    reset = 1'b0;
    clocks(2);
    checks++; if (sdo !== 1'b0)  begin fails++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    checks++; if (oe !== 1'b0)   begin fails++; $display("FAIL reset_oe: got %b want 0", oe); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (cc !== 16'd0)  begin fails++; $display("FAIL reset_count: got %0d want 0", cc); end
    checks++; if (err !== 3'b000) begin fails++; $display("FAIL reset_err: got %b want 000", err); end
  endtask

  task automatic test_basic();
    logic [15:0] w, e;
    logic        last;
    int          busy_n;
    handshake(16'hA5C3);
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL hs_ready_low: got %b want 0", ready); end
    model_start(e);
    cnv    = 1'b1;
    busy_n = 0;
    for (int k = 1; k <= 190; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (k == 170) cnv = 1'b0;
    end
    checks++; if (busy_n != 160) begin fails++; $display("FAIL busy_len: got %0d want 160", busy_n); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL ready_back: got %b want 1", ready); end
    read_bits(0, 16, 16, w, last);
    checks++; if (w !== e)       begin fails++; $display("FAIL basic_word: got %h want %h", w, e); end
    checks++; if (last !== 1'b0) begin fails++; $display("FAIL basic_sdo_done: got %b want 0", last); end
    checks++; if (oe !== 1'b1)   begin fails++; $display("FAIL basic_oe_done: got %b want 1", oe); end
    checks++; if (cc !== m_cc)   begin fails++; $display("FAIL basic_count: got %0d want %0d", cc, m_cc); end
    checks++; if (err !== m_err) begin fails++; $display("FAIL basic_err: got %b want %b", err, m_err); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 3 || (i == 2 && $urandom_range(0, 1) == 1)) handshake(16'($urandom));
      model_start(e);
      conv_phase(0, 170 + int'($urandom_range(0, 20)));
      read_bits(0, 16, 16, w, last);
      checks++; if (w !== e)     begin fails++; $display("FAIL rand_word%0d: got %h want %h", i, w, e); end
      checks++; if (cc !== m_cc) begin fails++; $display("FAIL rand_count%0d: got %0d want %0d", i, cc, m_cc); end
    end
  endtask

  task automatic test_ramp();
    logic [15:0] w;
    logic        last;
    logic [3:0]  er;
    for (int i = 0; i < 18; i++) begin
      er = 4'(m_ramp_n);
      m_ramp_n++;
      conv_phase(1, 12);
      read_bits(1, 4, 4, w, last);
      checks++; if (w[3:0] !== er) begin fails++; $display("FAIL ramp_word%0d: got %h want %h", i, w[3:0], er); end
    end
    checks++; if (cc_r !== 16'd18) begin fails++; $display("FAIL ramp_count: got %0d want 18", cc_r); end
    checks++; if (ready_r !== 1'b0) begin fails++; $display("FAIL ramp_ready: got %b want 0", ready_r); end
  endtask

  task automatic test_early();
    logic [15:0] w, e;
    logic        last;
    handshake(16'($urandom));
    model_start(e);
    m_err[0] = 1'b1;
    cnv = 1'b1;
    for (int k = 1; k <= 175; k++) begin
      @(negedge clk);
      if (k == 50) cnv = 1'b0;
      if (k == 162) begin
        checks++; if (oe !== 1'b0) begin fails++; $display("FAIL early_oe_pre: got %b want 0", oe); end
      end
      if (k == 163) begin
        checks++; if (oe !== 1'b1) begin fails++; $display("FAIL early_oe_on: got %b want 1", oe); end
        checks++; if (sdo !== e[15]) begin fails++; $display("FAIL early_msb: got %b want %b", sdo, e[15]); end
      end
    end
    read_bits(0, 16, 16, w, last);
    checks++; if (w !== e)       begin fails++; $display("FAIL early_word: got %h want %h", w, e); end
    checks++; if (err !== m_err) begin fails++; $display("FAIL early_err: got %b want %b", err, m_err); end
    pulse_clear();
  endtask

  task automatic test_retrig();
    logic [15:0] w, e;
    logic        last;
    int          busy_n;
    handshake(16'($urandom));
    model_start(e);
    m_err  = 3'b011;
    busy_n = 0;
    cnv    = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      cnv = ((k < 30) || (k >= 50 && k < 80)) ? 1'b1 : 1'b0;
    end
    checks++; if (busy_n != 160) begin fails++; $display("FAIL retrig_busy_len: got %0d want 160", busy_n); end
    checks++; if (cc !== m_cc)   begin fails++; $display("FAIL retrig_count: got %0d want %0d", cc, m_cc); end
    checks++; if (err !== m_err) begin fails++; $display("FAIL retrig_err: got %b want %b", err, m_err); end
    read_bits(0, 16, 16, w, last);
    checks++; if (w !== e) begin fails++; $display("FAIL retrig_word: got %h want %h", w, e); end
    pulse_clear();
    checks++; if (err !== 3'b000) begin fails++; $display("FAIL err_clear: got %b want 000", err); end
  endtask

  task automatic test_extra_sck();
    logic [15:0] w, e;
    logic        last;
    handshake(16'($urandom));
    model_start(e);
    conv_phase(0, 170);
    read_bits(0, 18, 16, w, last);
    m_err[2] = 1'b1;
    checks++; if (w !== e)       begin fails++; $display("FAIL extra_word: got %h want %h", w, e); end
    checks++; if (last !== 1'b0) begin fails++; $display("FAIL extra_sdo: got %b want 0", last); end
    checks++; if (err !== m_err) begin fails++; $display("FAIL extra_err: got %b want %b", err, m_err); end
    pulse_clear();
    handshake(16'($urandom));
    model_start(e);
    conv_phase(0, 170);
    read_bits(0, 8, 16, w, last);
    checks++; if (w[8:0] !== e[15:7]) begin fails++; $display("FAIL short_bits: got %h want %h", w[8:0], e[15:7]); end
    handshake(16'($urandom));
    model_start(e);
    cnv = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++; if (oe !== 1'b1) begin fails++; $display("FAIL short_oe_held: got %b want 1", oe); end
      end
      if (k == 3) begin
        checks++; if (oe !== 1'b0) begin fails++; $display("FAIL short_oe_drop: got %b want 0", oe); end
      end
    end
    cnv = 1'b0;
    clocks(10);
    read_bits(0, 16, 16, w, last);
    checks++; if (w !== e)       begin fails++; $display("FAIL short_next_word: got %h want %h", w, e); end
    checks++; if (err !== m_err) begin fails++; $display("FAIL short_err: got %b want %b", err, m_err); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w, e;
    logic        last;
    handshake(16'($urandom));
    model_start(e);
    conv_phase(0, 170);
    read_bits(0, 5, 16, w, last);
    #2 reset = 1'b1;
    #1;
    checks++; if (sdo !== 1'b0)   begin fails++; $display("FAIL amid_sdo: got %b want 0", sdo); end
    checks++; if (oe !== 1'b0)    begin fails++; $display("FAIL amid_oe: got %b want 0", oe); end
    checks++; if (busy !== 1'b0)  begin fails++; $display("FAIL amid_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL amid_ready: got %b want 1", ready); end
    checks++; if (cc !== 16'd0)   begin fails++; $display("FAIL amid_count: got %0d want 0", cc); end
    checks++; if (err !== 3'b000) begin fails++; $display("FAIL amid_err: got %b want 000", err); end
    clocks(2);
    reset    = 1'b0;
    m_full   = 1'b0;
    m_last   = '0;
    m_cc     = '0;
    m_err    = '0;
    m_ramp_n = 0;
    clocks(2);
    handshake(16'($urandom));
    model_start(e);
    conv_phase(0, 170);
    read_bits(0, 16, 16, w, last);
    checks++; if (w !== e)     begin fails++; $display("FAIL post_reset_word: got %h want %h", w, e); end
    checks++; if (cc !== m_cc) begin fails++; $display("FAIL post_reset_count: got %0d want %0d", cc, m_cc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_early();
    test_retrig();
    test_extra_sck();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ad7693_emulator.md
Name: ad7693_emulator

Overview:
- Synthesizable, clock-oversampled model of the AD7693 ADC in 3-wire mode without busy indicator. It is the responder end of the CNV/SCK/SDO interface that our ADC controller drives.
- It watches adc_cnv and adc_sck, runs a timed conversion, and shifts out a 16-bit word MSB-first on adc_sdo.
- It is used as a loopback target on the board and in the controller's bench.
- Sample values come either from a sample_in handshake or from an internal ramp.

Parameters:
- DATA_WIDTH, 16: width of the conversion word and of the shift register.
- CONV_CYCLES, 160: conversion time in fpga_clk cycles, measured from the synchronized CNV rising edge.
- SYNC_STAGES, 2: synchronizer depth on adc_cnv and adc_sck. Legal values are 2 or 3.
- PATTERN_MODE, 0: 0 takes words from sample_in; 1 uses an internal ramp that starts at 0 and adds 1 per conversion.

Ports:
- fpga_clk, input, 1: system clock. It must be at least 2*(SYNC_STAGES+2) times faster than the SCK frequency.
- reset, input, 1: asynchronous, active-high reset.
- adc_cnv, input, 1: convert strobe from the controller.
- adc_sck, input, 1: serial clock from the controller. Idles high.
- adc_sdo, output, 1: serial data out.
- adc_sdo_oe, output, 1: output enable for adc_sdo. 0 means high-Z at the pad.
- sample_in, input, DATA_WIDTH: next word to convert.
- sample_valid, input, 1: sample_in is valid.
- sample_ready, output, 1: the shadow register is empty.
- busy, output, 1: high while in CONVERT.
- conv_count, output, 16: number of accepted conversions. Wraps.
- err_flags, output, 3: sticky flags. [0] cnv_early, [1] cnv_retrig, [2] sck_extra.
- err_clear, input, 1: single-cycle pulse that clears err_flags.

Behaviour:
- Reset values: adc_sdo=0, adc_sdo_oe=0, busy=0, sample_ready=1, conv_count=0, err_flags=0, shadow=0, ramp=0. The FSM goes to IDLE. Reset asserted in any state aborts the frame immediately.
- Synchronization: adc_cnv and adc_sck each pass through SYNC_STAGES flops plus one edge-detect flop. Every edge event is therefore seen SYNC_STAGES+1 clocks after the pin changes.
- Sample handshake:
  - A transfer happens on a clock where sample_valid and sample_ready are both 1. The shadow is loaded and sample_ready goes to 0 on the next cycle.
  - At conversion start, the shadow is copied to the conversion register and sample_ready returns to 1.
  - If the shadow is empty at conversion start, the previous word is reused.
  - In PATTERN_MODE=1, sample_ready stays 0 and the ramp value is used instead.
- FSM states: IDLE, CONVERT, HOLD, SHIFT, DONE.
  - IDLE: adc_sdo_oe=0. On a synchronized CNV rise: load the conversion word, clear the cycle counter, increment conv_count, then go to CONVERT.
  - CONVERT: busy=1 and adc_sdo_oe=0. The counter runs to CONV_CYCLES-1.
    - CNV rising again in this state is ignored and sets err[1].
    - CNV falling in this state sets err[0].
    - When the count completes: go to SHIFT if CNV is low, otherwise go to HOLD.
  - HOLD: wait for a synchronized CNV fall, then go to SHIFT.
  - SHIFT:
    - On entry (first cycle), adc_sdo_oe=1 and adc_sdo=MSB.
    - Each synchronized SCK falling edge shifts left by one. adc_sdo presents the next bit and the bit index increments.
    - After DATA_WIDTH-1 falling edges, the LSB is on adc_sdo.
    - The DATA_WIDTH-th falling edge drives adc_sdo=0 and moves to DONE.
  - DONE: adc_sdo_oe=1 and adc_sdo=0. Further SCK falling edges set err[2].
  - From SHIFT or DONE, a CNV rise starts a new conversion exactly as from IDLE (short reads are allowed and flag nothing). The output enable drops on that same cycle.
- Simultaneous events: if err_clear and an error event occur on the same cycle, the event wins and the flag stays set. SCK edges outside SHIFT/DONE are ignored.
- Ramp arithmetic: DATA_WIDTH-bit add, wraps from 0xFFFF to 0x0000. conv_count wraps from 0xFFFF to 0.

Decomposition:
- Shared package ad7693_pkg holds:
  - FSM state encoding, one-hot 5-bit;
  - err_flags bit indices;
  - the default DATA_WIDTH and CONV_CYCLES constants shared with the controller.
- One sub-module: ad7693_sync_edge. It is a parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated twice (CNV and SCK).

Test Plan:
- Load 0xA5C3 via handshake, pulse CNV high for 170 clocks, then issue 16 SCK pulses with a 5-clock half-period. Required: busy high for exactly 160 clocks; the captured word is 0xA5C3; conv_count=1; err_flags=0.
- Run with PATTERN_MODE=1 for three frames. Required: words 0x0000, 0x0001, 0x0002; after a forced wrap from 0xFFFF the next word is 0x0000.
- Drop CNV 50 clocks after it rises. Required: err[0]=1; SDO is enabled with the MSB when the 160-count completes; the word is still read correctly.
- Raise CNV again during CONVERT. Required: conversion timing unchanged; err[1]=1; conv_count increments only once. Then pulse err_clear. Required: err_flags=0.
- Issue 18 SCK falling edges in one frame. Required: bits 0 through 15 correct; adc_sdo=0 afterwards; err[2]=1. Start a new CNV after 8 bits. Required: adc_sdo_oe drops and no flag is set.
- Assert reset mid-SHIFT. Required: all outputs return to their reset values immediately (asynchronously) and the next frame operates normally.
